// File: rtl/config_regbank_shadowed_if.sv
// ---------------------------------------------------------------------------
// config_regbank_shadowed_if
// Register-access bus between the PCIe register decoder (master) and the
// shadowed configuration register bank (slave).
//   wr_valid / wr_ready : write handshake, transfer when both are high
//   wr_addr / wr_data   : write register index and data
//   rd_en / rd_addr     : read request (always accepted) and register index
//   rd_data / rd_valid  : read response, one cycle after rd_en
// ---------------------------------------------------------------------------
interface config_regbank_shadowed_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/config_regbank_shadowed.sv
// ---------------------------------------------------------------------------
// config_regbank_shadowed
// Bank of NUM_REGS configuration registers written from the PCIe DMA engine.
// Registers flagged in COMMIT_MASK are shadowed: writes land in a staging
// copy and become active one cycle after a commit strobe. Other registers
// are direct and take effect on the write edge.
// Optional feature macro: CFG_LOCK_EN (adds cfg_lock input that rejects
// writes while high).
// Ports:
//   PCIE_dma_engine_clk : clock, rising edge
//   rst                 : synchronous reset, active-high
//   bus                 : register access bus (slave modport)
//   commit              : pulse, apply staged shadow values
//   cfg_lock            : (CFG_LOCK_EN only) reject writes while high
//   cfg_out             : active values, reg i at [i*DATA_W +: DATA_W]
//   cfg_update          : per-register 1-cycle change pulse
//   pending             : staged shadow write waiting for commit
//   wr_err              : 1-cycle pulse on a rejected write
//   err_cnt             : saturating count of wr_err pulses
// ---------------------------------------------------------------------------
module config_regbank_shadowed #(
    parameter int                            NUM_REGS    = 4,
    parameter int                            DATA_W      = 8,
    parameter int                            ADDR_W      = 4,
    parameter logic [NUM_REGS*DATA_W-1:0]    RST_VALS    = {8'd0, 8'd0, 8'd0, 8'd25},
    parameter logic [NUM_REGS-1:0]           COMMIT_MASK = 4'b0110
) (
    input  logic                         PCIE_dma_engine_clk,
    input  logic                         rst,
    config_regbank_shadowed_if.slave     bus,
    input  logic                         commit,
`ifdef CFG_LOCK_EN
    input  logic                         cfg_lock,
`endif
    output logic [NUM_REGS*DATA_W-1:0]   cfg_out,
    output logic [NUM_REGS-1:0]          cfg_update,
    output logic                         pending,
    output logic                         wr_err,
    output logic [7:0]                   err_cnt
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [DATA_W-1:0]   active_r     [NUM_REGS];
    logic [DATA_W-1:0]   shadow_r     [NUM_REGS];
    logic [DATA_W-1:0]   active_nxt_s [NUM_REGS];
    logic [DATA_W-1:0]   shadow_nxt_s [NUM_REGS];
    logic [NUM_REGS-1:0] upd_s;
    logic [NUM_REGS-1:0] cfg_update_r;

    logic                wr_ready_s;
    logic                apply_s;
    logic                lock_s;
    logic                wr_fire_s;
    logic                in_range_s;
    logic                wr_ok_s;
    logic                wr_bad_s;
    logic                shadow_wr_s;
    logic                pending_r;
    logic                wr_err_r;
    logic [7:0]          err_cnt_r;
    logic [DATA_W-1:0]   rd_mux_s;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;

`ifdef CFG_LOCK_EN
    assign lock_s = cfg_lock;
`else
    assign lock_s = 1'b0;
`endif

    // Out-of-range and locked writes are still accepted on the bus, only discarded.
    assign wr_fire_s  = bus.wr_valid & wr_ready_s;
    assign in_range_s = ({1'b0, bus.wr_addr} < NUM_REGS_L);
    assign wr_ok_s    = wr_fire_s & in_range_s & ~lock_s;
    assign wr_bad_s   = wr_fire_s & (~in_range_s | lock_s);

    // FSM state register.
    always_ff @(posedge PCIE_dma_engine_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a commit only matters if something is staged, including a
    // shadow write accepted in the very same cycle.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (commit && (pending_r || shadow_wr_s)) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: writes are held off for the single COMMIT cycle.
    always_comb begin
        wr_ready_s = 1'b1;
        apply_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_ready_s = 1'b1;
                apply_s    = 1'b0;
            end
            ST_COMMIT: begin
                wr_ready_s = 1'b0;
                apply_s    = 1'b1;
            end
            default: begin
                wr_ready_s = 1'b1;
                apply_s    = 1'b0;
            end
        endcase
    end

    assign bus.wr_ready = wr_ready_s;

    // Next register values and change detection; writes and commit application
    // never coincide because wr_ready is low during COMMIT.
    always_comb begin
        shadow_wr_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            active_nxt_s[i] = active_r[i];
            shadow_nxt_s[i] = shadow_r[i];
            if (wr_ok_s && ({1'b0, bus.wr_addr} == (ADDR_W+1)'(i))) begin
                if (COMMIT_MASK[i]) begin
                    shadow_nxt_s[i] = bus.wr_data;
                    shadow_wr_s     = 1'b1;
                end else begin
                    active_nxt_s[i] = bus.wr_data;
                end
            end else if (apply_s && COMMIT_MASK[i]) begin
                active_nxt_s[i] = shadow_r[i];
            end else begin
                active_nxt_s[i] = active_r[i];
            end
            upd_s[i] = (active_nxt_s[i] != active_r[i]);
        end
    end

    // Active and shadow register storage plus change pulses.
    always_ff @(posedge PCIE_dma_engine_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_r[i] <= RST_VALS[i*DATA_W +: DATA_W];
                shadow_r[i] <= RST_VALS[i*DATA_W +: DATA_W];
            end
            cfg_update_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_r[i] <= active_nxt_s[i];
                shadow_r[i] <= shadow_nxt_s[i];
            end
            cfg_update_r <= upd_s;
        end
    end

    // Pending flag, error pulse and saturating error counter.
    always_ff @(posedge PCIE_dma_engine_clk) begin
        if (rst) begin
            pending_r <= 1'b0;
            wr_err_r  <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            if (apply_s) begin
                pending_r <= 1'b0;
            end else if (shadow_wr_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            wr_err_r <= wr_bad_s;
            if (wr_bad_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    // Read mux: software sees the staged value for shadowed registers.
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, bus.rd_addr} == (ADDR_W+1)'(i)) begin
                rd_mux_s = COMMIT_MASK[i] ? shadow_r[i] : active_r[i];
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    // Read response register; data holds between reads.
    always_ff @(posedge PCIE_dma_engine_clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_r <= rd_mux_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;

    // Flatten active registers onto the datapath bus.
    always_comb begin
        cfg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_out[i*DATA_W +: DATA_W] = active_r[i];
        end
    end

    assign cfg_update = cfg_update_r;
    assign pending    = pending_r;
    assign wr_err     = wr_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_config_regbank_shadowed.sv
// ---------------------------------------------------------------------------
// tb_config_regbank_shadowed
// Directed bench for config_regbank_shadowed: read responses are checked
// against a queue of expected values filled when each read is issued.
// ---------------------------------------------------------------------------
module tb_config_regbank_shadowed;

    logic        clk;
    logic        rst;
    logic        commit;
    logic        cfg_lock;
    logic [31:0] cfg_out;
    logic [3:0]  cfg_update;
    logic        pending;
    logic        wr_err;
    logic [7:0]  err_cnt;

    int          checks;
    int          failures;
    logic [7:0]  sb_q [$];

    config_regbank_shadowed_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    config_regbank_shadowed dut (
        .PCIE_dma_engine_clk (clk),
        .rst                 (rst),
        .bus                 (bus),
        .commit              (commit),
`ifdef CFG_LOCK_EN
        .cfg_lock            (cfg_lock),
`endif
        .cfg_out             (cfg_out),
        .cfg_update          (cfg_update),
        .pending             (pending),
        .wr_err              (wr_err),
        .err_cnt             (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [3:0] addr, input logic [7:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        sb_q.push_back(exp);
    endtask

    // Read-response scoreboard, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst && bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("rd_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", 32'(bus.rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        commit        = 1'b0;
        cfg_lock      = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = 4'd0;
        bus.wr_data   = 8'd0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = 4'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        chk("rst_cfg_out", cfg_out, 32'h0000_0019);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_cfg_update", 32'(cfg_update), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        step();
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Direct write to reg0.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h40;
        step();
        bus.wr_valid = 1'b0;
        chk("direct_reg0", 32'(cfg_out[7:0]), 32'h40);
        chk("direct_update", 32'(cfg_update), 32'b0001);
        step();
        chk("direct_update_end", 32'(cfg_update), 32'd0);

        // Shadow write to reg1, read-back of staged value, then commit.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 8'h02;
        step();
        bus.wr_valid = 1'b0;
        chk("shadow_pending", 32'(pending), 32'd1);
        chk("shadow_reg1_inactive", 32'(cfg_out[15:8]), 32'h00);
        chk("shadow_no_update", 32'(cfg_update), 32'd0);
        issue_read(4'd1, 8'h02);
        step();
        bus.rd_en = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("commit_wr_ready_low", 32'(bus.wr_ready), 32'd0);
        chk("commit_reg1_not_yet", 32'(cfg_out[15:8]), 32'h00);
        step();
        chk("commit_wr_ready_back", 32'(bus.wr_ready), 32'd1);
        chk("commit_reg1", 32'(cfg_out[15:8]), 32'h02);
        chk("commit_update", 32'(cfg_update), 32'b0010);
        chk("commit_pending_clr", 32'(pending), 32'd0);
        step();
        chk("commit_update_end", 32'(cfg_update), 32'd0);

        // Write reg2 and commit in the same cycle.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'h07;
        commit = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        commit = 1'b0;
        chk("same_cycle_wr_ready", 32'(bus.wr_ready), 32'd0);
        step();
        chk("same_cycle_reg2", 32'(cfg_out[23:16]), 32'h07);
        chk("same_cycle_update", 32'(cfg_update), 32'b0100);
        chk("same_cycle_pending", 32'(pending), 32'd0);

        // Commit with nothing pending is ignored.
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("idle_commit_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("idle_commit_update", 32'(cfg_update), 32'd0);
        step();
        chk("idle_commit_update2", 32'(cfg_update), 32'd0);

        // Committing an unchanged shadow value produces no pulse.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 8'h02;
        commit = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        commit = 1'b0;
        chk("same_val_in_commit", 32'(bus.wr_ready), 32'd0);
        step();
        chk("same_val_no_update", 32'(cfg_update), 32'd0);
        chk("same_val_pending", 32'(pending), 32'd0);

        // Read and write the same address together: old value returned.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h55;
        issue_read(4'd0, 8'h40);
        step();
        bus.wr_valid = 1'b0;
        issue_read(4'd5, 8'h00);
        step();
        issue_read(4'd3, 8'h00);
        step();
        bus.rd_en = 1'b0;
        chk("rw_reg0_new", 32'(cfg_out[7:0]), 32'h55);
        step();
        chk("rd_hold_valid", 32'(bus.rd_valid), 32'd0);
        chk("rd_hold_data", 32'(bus.rd_data), 32'h00);

        // Out-of-range write.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'hA; bus.wr_data = 8'hEE;
        step();
        bus.wr_valid = 1'b0;
        chk("oor_wr_err", 32'(wr_err), 32'd1);
        chk("oor_err_cnt", 32'(err_cnt), 32'd1);
        chk("oor_cfg_out", cfg_out, 32'h0007_0255);
        step();
        chk("oor_wr_err_end", 32'(wr_err), 32'd0);

        // Saturation of the error counter.
        bus.wr_valid = 1'b1;
        for (int k = 0; k < 253; k++) step();
        chk("err_cnt_254", 32'(err_cnt), 32'd254);
        for (int k = 0; k < 46; k++) step();
        bus.wr_valid = 1'b0;
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
        chk("err_cfg_out", cfg_out, 32'h0007_0255);
        step();

        // Reset arriving during COMMIT wins with no pulses.
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 8'h09;
        commit = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        commit = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_commit_update", 32'(cfg_update), 32'd0);
        chk("rst_commit_cfg", cfg_out, 32'h0000_0019);
        chk("rst_commit_pending", 32'(pending), 32'd0);
        chk("rst_commit_err_cnt", 32'(err_cnt), 32'd0);
        step();
        chk("rst_commit_update2", 32'(cfg_update), 32'd0);

`ifdef CFG_LOCK_EN
        // Locked writes are rejected and counted.
        cfg_lock = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h11;
        step();
        bus.wr_valid = 1'b0;
        chk("lock_reg0", 32'(cfg_out[7:0]), 32'h19);
        chk("lock_wr_err", 32'(wr_err), 32'd1);
        chk("lock_err_cnt", 32'(err_cnt), 32'd1);
        cfg_lock = 1'b0;
        bus.wr_valid = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        chk("unlock_reg0", 32'(cfg_out[7:0]), 32'h11);
        chk("unlock_wr_err", 32'(wr_err), 32'd0);
`endif

        // Drain the read scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) step();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
